// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: drives an external registered Feistel round unit and runs the C/D key schedule.
// Optional abort input is compiled in when DES_SEQ_ABORT_EN is defined.
module des_round_sequencer #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [55:0] in_key_cd,
  input  logic        in_decrypt,
  output logic [31:0] round_l_o,
  output logic [31:0] round_r_o,
  output logic [55:0] round_cd_o,
  input  logic [31:0] round_l_i,
  input  logic [31:0] round_r_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy_o,
`ifdef DES_SEQ_ABORT_EN
  input  logic        abort_i,
`endif
  output logic [4:0]  round_idx_o
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_CAPTURE, S_DONE} state_e;

  localparam logic [4:0] LAST = 5'(NUM_ROUNDS);

  function automatic logic shift2(input logic [4:0] r);
    return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
  endfunction

  function automatic logic [27:0] rol28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] ror28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] l0_q, r0_q;
  logic        dec_q;
  logic [55:0] cd_q, cd_d;
  logic        out_valid_q;
  logic [63:0] out_data_q;
  logic        abort;
  logic [4:0]  sidx;
  logic        two;

`ifdef DES_SEQ_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  // Encrypt walks the schedule forward (key for round cnt+1); decrypt walks it backward.
  assign sidx = dec_q ? (5'd17 - cnt_q) : (cnt_q + 5'd1);
  assign two  = shift2(sidx);
  assign cd_d = dec_q ? {ror28(cd_q[55:28], two), ror28(cd_q[27:0], two)}
                      : {rol28(cd_q[55:28], two), rol28(cd_q[27:0], two)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      l0_q        <= '0;
      r0_q        <= '0;
      dec_q       <= 1'b0;
      cd_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          l0_q    <= in_data[63:32];
          r0_q    <= in_data[31:0];
          dec_q   <= in_decrypt;
          cnt_q   <= 5'd1;
          cd_q    <= in_decrypt ? in_key_cd
                                : {rol28(in_key_cd[55:28], 1'b0), rol28(in_key_cd[27:0], 1'b0)};
          state_q <= S_ROUND;
        end
        S_ROUND: begin
          if (abort) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= S_CAPTURE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
            cd_q  <= cd_d;
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else begin
            out_data_q  <= {round_r_i, round_l_i};
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Round 1 feeds the latched block; later rounds loop the round unit's registered output back.
  always_comb begin
    round_l_o = l0_q;
    round_r_o = r0_q;
    if (state_q == S_ROUND && cnt_q != 5'd1) begin
      round_l_o = round_l_i;
      round_r_o = round_r_i;
    end
  end

  assign round_cd_o  = cd_q;
  assign in_ready    = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign round_idx_o = cnt_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench: wraps the sequencer with IP/PC-1/PC-2/FP wiring and a registered round unit,
// and checks results against a plain DES reference model.
module tb_des_round_sequencer;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                              2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                                19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-IP_T[i]];
    return r;
  endfunction
  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = x[64-FP_T[i]];
    return r;
  endfunction
  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = x[64-PC1_T[i]];
    return r;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = x[56-PC2_T[i]];
    return r;
  endfunction
  function automatic logic [31:0] feist(input logic [31:0] rin, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, r;
    logic [5:0]  b;
    int row, col;
    for (int i = 0; i < 48; i++) x[47-i] = rin[32-E_T[i]];
    x = x ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = x[47-6*j -: 6];
      row = int'({b[5], b[0]});
      col = int'(b[4:1]);
      s[31-4*j -: 4] = 4'(SB[j][row*16+col]);
    end
    for (int i = 0; i < 32; i++) r[31-i] = s[32-P_T[i]];
    return r;
  endfunction

  function automatic int shifts(input int i);
    return (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
  endfunction
  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input int n);
    logic [27:0] c, d;
    c = cd[55:28]; d = cd[27:0];
    c = (c << (n % 28)) | (c >> (28 - n % 28));
    d = (d << (n % 28)) | (d >> (28 - n % 28));
    return {c, d};
  endfunction
  // Key state expected while round k is being computed.
  function automatic logic [55:0] cd_ref(input logic [55:0] cd0, input int k, input logic dec);
    int n, tot;
    n = dec ? 17 - k : k;
    tot = 0;
    for (int i = 1; i <= n; i++) tot += shifts(i);
    return rot_cd(cd0, tot);
  endfunction
  function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk, input logic dec);
    logic [47:0] ks [1:16];
    logic [55:0] cd;
    logic [63:0] x;
    logic [31:0] l, r, t;
    cd = pc1(key);
    for (int i = 1; i <= 16; i++) begin
      cd = rot_cd(cd, shifts(i));
      ks[i] = pc2(cd);
    end
    x = ip(blk);
    l = x[63:32]; r = x[31:0];
    for (int i = 1; i <= 16; i++) begin
      t = r;
      r = l ^ feist(r, dec ? ks[17-i] : ks[i]);
      l = t;
    end
    return fp({r, l});
  endfunction

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, in_decrypt, out_valid, out_ready, busy_o, abort_i;
  logic [63:0] in_data, out_data;
  logic [55:0] in_key_cd, round_cd_o;
  logic [31:0] round_l_o, round_r_o, ru_l, ru_r;
  logic [4:0]  round_idx_o;
  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  des_round_sequencer #(.NUM_ROUNDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key_cd(in_key_cd), .in_decrypt(in_decrypt),
    .round_l_o(round_l_o), .round_r_o(round_r_o), .round_cd_o(round_cd_o),
    .round_l_i(ru_l), .round_r_i(ru_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy_o(busy_o),
`ifdef DES_SEQ_ABORT_EN
    .abort_i(abort_i),
`endif
    .round_idx_o(round_idx_o));

  // Registered Feistel round unit with PC-2 applied to the sequencer's C||D.
  always @(posedge clk) begin
    ru_l <= round_r_o;
    ru_r <= round_l_o ^ feist(round_r_o, pc2(round_cd_o));
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, out_data, 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
    check({tag, "_idx"}, 64'(round_idx_o), 64'd0);
    check({tag, "_cd"}, 64'(round_cd_o), 64'd0);
    check({tag, "_lr"}, {round_l_o, round_r_o}, 64'd0);
  endtask

  // One transaction; rst_rd/abort_rd/pulse_rd = round at which to inject (0 = never).
  task automatic run(input logic [63:0] key, input logic [63:0] blk, input logic dec, input int hold,
                     input int rst_rd, input int abort_rd, input int pulse_rd, output logic [63:0] res);
    logic [55:0] kcd;
    logic [63:0] ipb, held;
    kcd = pc1(key);
    ipb = ip(blk);
    res = '0;
    in_data = ipb; in_key_cd = kcd; in_decrypt = dec; in_valid = 1'b1;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_decrypt = ~dec; in_data = {$urandom, $urandom}; in_key_cd = {$urandom, $urandom};
    for (int k = 1; k <= 16; k++) begin
      check("round_idx", 64'(round_idx_o), 64'(k));
      check("round_cd", 64'(round_cd_o), 64'(cd_ref(kcd, k, dec)));
      if (k == 1) check("round1_lr", {round_l_o, round_r_o}, ipb);
      if (k == pulse_rd) begin
        check("in_ready_busy", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_data = ip(~blk); in_decrypt = ~dec;
      end
      if (k == pulse_rd + 1) in_valid = 1'b0;
      if (k == rst_rd) begin
        rst_n = 1'b0;
        #1;
        reset_vals("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'd1);
        return;
      end
`ifdef DES_SEQ_ABORT_EN
      if (k == abort_rd) begin
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_idx", 64'(round_idx_o), 64'd0);
        repeat (3) begin
          check("abort_no_valid", 64'(out_valid), 64'd0);
          @(negedge clk);
        end
        return;
      end
`endif
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("capture_valid_low", 64'(out_valid), 64'd0);
    check("capture_busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    check("out_valid_t0p17", 64'(out_valid), 64'd1);
    res  = fp(out_data);
    held = out_data;
    check("result", res, des_ref(key, blk, dec));
    for (int h = 0; h < hold; h++) begin
      check("hold_data", out_data, held);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_accept_valid", 64'(out_valid), 64'd0);
    check("post_accept_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] res, key, blk;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key_cd = '0; in_decrypt = 1'b0;
    out_ready = 1'b0; abort_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    key = 64'h133457799BBCDFF1;
    run(key, 64'h0123456789ABCDEF, 1'b0, 0, 0, 0, 0, res);
    check("kat_encrypt", res, 64'h85E813540F0AB405);
    run(key, 64'h85E813540F0AB405, 1'b1, 0, 0, 0, 0, res);
    check("kat_decrypt", res, 64'h0123456789ABCDEF);
    run({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 10, 0, 0, 0, res);
    run({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 2, 0, 0, 4, res);
    run(key, 64'h0123456789ABCDEF, 1'b0, 0, 8, 0, 0, res);
    run(key, 64'h0123456789ABCDEF, 1'b0, 0, 0, 0, 0, res);
    check("kat_after_reset", res, 64'h85E813540F0AB405);
`ifdef DES_SEQ_ABORT_EN
    run({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 0, 5, 0, res);
    run(key, 64'h0123456789ABCDEF, 1'b0, 0, 0, 0, 0, res);
    check("kat_after_abort", res, 64'h85E813540F0AB405);
`endif
    for (int t = 0; t < 8; t++)
      run({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), 0, 0, 0, res);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
